// File: rtl/banco_regs_2r1w.sv
// -----------------------------------------------------------------------------
// banco_regs_2r1w
//   General-purpose register file for the core datapath: two registered read
//   ports (operand A/B), one write port (writeback), write-to-read bypass,
//   optional hardwired-zero entry 0 and a sequenced clear engine that zeroes
//   the whole array after reset or on request.
//
// Ports
//   clock                      rising-edge clock
//   reset_n                    asynchronous active-low reset
//   clear                      request full-array zeroing (sampled when ready=1)
//   ready                      1 = array usable, 0 = clear sweep running
//   wr_en / wr_addr / wr_data  write port
//   rd_en_a / rd_addr_a        port A read request
//   rd_data_a / rd_valid_a     port A registered data and valid strobe
//   rd_en_b / rd_addr_b        port B read request
//   rd_data_b / rd_valid_b     port B registered data and valid strobe
// -----------------------------------------------------------------------------
module banco_regs_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  output logic                  ready,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic                  rd_valid_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_valid_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    in_ready;
  logic                    wr_fire;     // write accepted this cycle (clear wins)
  logic                    wr_commit;   // write actually changes the array
  logic                    zero_wr;
  logic                    zero_a;
  logic                    zero_b;
  logic [DATA_WIDTH-1:0]   sel_a;
  logic [DATA_WIDTH-1:0]   sel_b;

  assign in_ready  = (state == ST_READY);
  assign wr_fire   = in_ready && wr_en && !clear;

  assign zero_wr   = (ZERO_REG != 0) && (wr_addr   == '0);
  assign zero_a    = (ZERO_REG != 0) && (rd_addr_a == '0);
  assign zero_b    = (ZERO_REG != 0) && (rd_addr_b == '0);

  assign wr_commit = wr_fire && !zero_wr;

  // Read value priority: hardwired zero, then bypass of the write landing at
  // this same edge, then the stored entry.
  assign sel_a = zero_a                           ? '0      :
                 (wr_fire && wr_addr == rd_addr_a) ? wr_data :
                                                    mem[rd_addr_a];
  assign sel_b = zero_b                           ? '0      :
                 (wr_fire && wr_addr == rd_addr_b) ? wr_data :
                                                    mem[rd_addr_b];

  // Control FSM: the sweep counter walks every entry once, then hands over.
  // ready is registered and tracks the state it is leaving/entering.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_CLEAR;
      sweep_cnt <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);   // wraps to 0 after LAST_ADDR
          if (sweep_cnt == LAST_ADDR) begin
            state <= ST_READY;
            ready <= 1'b1;
          end
        end
        ST_READY: begin
          if (clear) begin
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
            ready     <= 1'b0;
          end
        end
        default: begin
          state     <= ST_CLEAR;
          sweep_cnt <= '0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  // Storage array.
  // NOTE: the array has no reset branch on purpose; the clear sweep zeroes it,
  // which keeps it mappable onto plain RAM/flop arrays without reset fan-out.
  always_ff @(posedge clock) begin
    if (!in_ready) begin
      mem[sweep_cnt] <= '0;
    end else if (wr_commit) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Port A: data holds when not reading, valid is a one-cycle strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_a  <= '0;
      rd_valid_a <= 1'b0;
    end else if (in_ready && rd_en_a) begin
      rd_data_a  <= sel_a;
      rd_valid_a <= 1'b1;
    end else begin
      rd_valid_a <= 1'b0;
    end
  end

  // Port B: identical behaviour, independent request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_b  <= '0;
      rd_valid_b <= 1'b0;
    end else if (in_ready && rd_en_b) begin
      rd_data_b  <= sel_b;
      rd_valid_b <= 1'b1;
    end else begin
      rd_valid_b <= 1'b0;
    end
  end

endmodule

// File: tb/tb_banco_regs_2r1w.sv
// -----------------------------------------------------------------------------
// tb_banco_regs_2r1w
//   Drives two copies of banco_regs_2r1w (ZERO_REG=1 and ZERO_REG=0) with the
//   same stimulus and compares both against a behavioural model built from
//   plain arrays: directed scenarios first, then a randomized run.
// -----------------------------------------------------------------------------
module tb_banco_regs_2r1w;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2 ** AW;

  logic          clock;
  logic          reset_n;
  logic          clear;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en_a;
  logic [AW-1:0] rd_addr_a;
  logic          rd_en_b;
  logic [AW-1:0] rd_addr_b;

  logic          ready_z,   ready_n;
  logic [DW-1:0] rd_data_a_z, rd_data_b_z, rd_data_a_n, rd_data_b_n;
  logic          rd_valid_a_z, rd_valid_b_z, rd_valid_a_n, rd_valid_b_n;

  banco_regs_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut_z (
    .clock(clock), .reset_n(reset_n), .clear(clear), .ready(ready_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a_z), .rd_valid_a(rd_valid_a_z),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b_z), .rd_valid_b(rd_valid_b_z)
  );

  banco_regs_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut_n (
    .clock(clock), .reset_n(reset_n), .clear(clear), .ready(ready_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a_n), .rd_valid_a(rd_valid_a_n),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b_n), .rd_valid_b(rd_valid_b_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: array contents plus the number of sweep edges done.
  logic [DW-1:0] mz [DEPTH];
  logic [DW-1:0] mn [DEPTH];
  bit            m_ready;
  int            m_swept;
  logic [DW-1:0] e_da_z, e_db_z, e_da_n, e_db_n;
  bit            e_va, e_vb;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ready_z"}, DW'(ready_z),      DW'(m_ready));
    check({tag, ".ready_n"}, DW'(ready_n),      DW'(m_ready));
    check({tag, ".va_z"},    DW'(rd_valid_a_z), DW'(e_va));
    check({tag, ".vb_z"},    DW'(rd_valid_b_z), DW'(e_vb));
    check({tag, ".va_n"},    DW'(rd_valid_a_n), DW'(e_va));
    check({tag, ".vb_n"},    DW'(rd_valid_b_n), DW'(e_vb));
    check({tag, ".da_z"},    rd_data_a_z,       e_da_z);
    check({tag, ".db_z"},    rd_data_b_z,       e_db_z);
    check({tag, ".da_n"},    rd_data_a_n,       e_da_n);
    check({tag, ".db_n"},    rd_data_b_n,       e_db_n);
  endtask

  function automatic logic [DW-1:0] pick(input bit zr, input int ra, input bit byp,
                                         input logic [DW-1:0] stored);
    if (zr && ra == 0)              return '0;
    if (byp && int'(wr_addr) == ra) return wr_data;
    return stored;
  endfunction

  // Applies the effect of one rising edge given the inputs currently driven.
  task automatic model_edge();
    bit byp;
    if (!m_ready) begin
      mz[m_swept] = '0;
      mn[m_swept] = '0;
      m_swept++;
      e_va = 0;
      e_vb = 0;
      if (m_swept == DEPTH) begin
        m_ready = 1;
        m_swept = 0;
      end
    end else begin
      byp = wr_en && !clear;
      e_va = rd_en_a;
      e_vb = rd_en_b;
      if (rd_en_a) begin
        e_da_z = pick(1, int'(rd_addr_a), byp, mz[rd_addr_a]);
        e_da_n = pick(0, int'(rd_addr_a), byp, mn[rd_addr_a]);
      end
      if (rd_en_b) begin
        e_db_z = pick(1, int'(rd_addr_b), byp, mz[rd_addr_b]);
        e_db_n = pick(0, int'(rd_addr_b), byp, mn[rd_addr_b]);
      end
      if (clear) begin
        m_ready = 0;
        m_swept = 0;
      end else if (wr_en) begin
        if (wr_addr != 0) mz[wr_addr] = wr_data;
        mn[wr_addr] = wr_data;
      end
    end
  endtask

  task automatic model_reset();
    m_ready = 0;
    m_swept = 0;
    e_va = 0;
    e_vb = 0;
    e_da_z = '0; e_db_z = '0; e_da_n = '0; e_db_n = '0;
  endtask

  task automatic idle();
    clear = 0; wr_en = 0; rd_en_a = 0; rd_en_b = 0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
  endtask

  // One clock: edge, model update, sample 1 ns later.
  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic write_cmd(input int a, input logic [DW-1:0] d);
    wr_en = 1; wr_addr = AW'(a); wr_data = d;
  endtask

  // Full sweep after reset/clear: ready must stay low until the 32nd edge.
  task automatic sweep(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      step(tag);
      check({tag, ".ready_edge"}, DW'(ready_z), DW'(i == DEPTH));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mz[i] = 'x;
      mn[i] = 'x;
    end
    idle();
    reset_n = 1;
    #1;
    reset_n = 0;
    model_reset();
    #10;
    check_all("rst");
    #10;                        // release between edges
    reset_n = 1;

    // 1. Sweep after reset, then read an untouched entry.
    sweep("sweep0");
    rd_en_a = 1; rd_addr_a = AW'(7);
    step("rd7");
    check("rd7.data", rd_data_a_z, 32'h0);
    idle();
    step("rd7_off");
    check("rd7.valid_drop", DW'(rd_valid_a_z), DW'(0));

    // 2. Write then read on both ports.
    write_cmd(5, 32'hDEADBEEF);
    step("wr5");
    idle();
    rd_en_a = 1; rd_addr_a = AW'(5);
    rd_en_b = 1; rd_addr_b = AW'(5);
    step("rd5");
    check("rd5.a", rd_data_a_z, 32'hDEADBEEF);
    check("rd5.b", rd_data_b_z, 32'hDEADBEEF);
    idle();

    // 3. Bypass over a previous value of 1.
    write_cmd(9, 32'h1);
    step("wr9");
    write_cmd(9, 32'h12345678);
    rd_en_a = 1; rd_addr_a = AW'(9);
    rd_en_b = 1; rd_addr_b = AW'(9);
    step("byp9");
    check("byp9.a", rd_data_a_z, 32'h12345678);
    check("byp9.b", rd_data_b_n, 32'h12345678);
    idle();

    // 4. Entry 0: hardwired zero vs ordinary register.
    write_cmd(0, 32'hFFFFFFFF);
    rd_en_b = 1; rd_addr_b = '0;
    step("wr0");
    check("wr0.z", rd_data_b_z, 32'h0);
    idle();
    rd_en_b = 1; rd_addr_b = '0;
    step("rd0");
    check("rd0.z", rd_data_b_z, 32'h0);
    check("rd0.n", rd_data_b_n, 32'hFFFFFFFF);
    idle();

    // 5. Clear request with a colliding write; stimulus during the sweep is ignored.
    write_cmd(3, 32'hA5A5A5A5);
    step("wr3");
    idle();
    clear = 1;
    write_cmd(4, 32'h77);
    rd_en_a = 1; rd_addr_a = AW'(3);
    step("clr");
    check("clr.read_done", rd_data_a_z, 32'hA5A5A5A5);
    idle();
    for (int i = 1; i <= DEPTH; i++) begin
      write_cmd(int'($urandom_range(DEPTH - 1)), $urandom);
      clear   = 1'($urandom_range(1));
      rd_en_a = 1; rd_addr_a = AW'($urandom_range(DEPTH - 1));
      rd_en_b = 1; rd_addr_b = AW'($urandom_range(DEPTH - 1));
      step("clr_sweep");
      check("clr_sweep.ready_edge", DW'(ready_z), DW'(i == DEPTH));
    end
    idle();
    rd_en_a = 1; rd_addr_a = AW'(3);
    rd_en_b = 1; rd_addr_b = AW'(4);
    step("post_clr");
    check("post_clr.a3", rd_data_a_n, 32'h0);
    check("post_clr.b4", rd_data_b_n, 32'h0);

    // 6. Async reset in the middle of a sweep.
    write_cmd(6, 32'hCAFEF00D);
    rd_en_a = 1; rd_addr_a = AW'(6);
    step("pre_mid");
    idle();
    clear = 1;
    step("clr2");
    idle();
    for (int i = 0; i < 10; i++) step("mid");
    #3;
    reset_n = 0;
    model_reset();
    #1;
    check_all("mid_rst");
    check("mid_rst.ready", DW'(ready_z), DW'(0));
    #4;
    reset_n = 1;
    sweep("sweep2");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      wr_en     = 1'($urandom_range(1));
      wr_addr   = ($urandom_range(7) == 0) ? '0 : AW'($urandom_range(DEPTH - 1));
      wr_data   = $urandom;
      clear     = ($urandom_range(199) == 0);
      rd_en_a   = ($urandom_range(3) != 0);
      rd_en_b   = ($urandom_range(3) != 0);
      rd_addr_a = ($urandom_range(3) == 0) ? wr_addr : AW'($urandom_range(DEPTH - 1));
      rd_addr_b = ($urandom_range(3) == 0) ? wr_addr : AW'($urandom_range(DEPTH - 1));
      if ($urandom_range(1499) == 0) begin
        #3;
        reset_n = 0;
        model_reset();
        #1;
        check_all("rnd_rst");
        #3;
        reset_n = 1;
      end
      step("rnd");
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
